// File: rtl/case_op_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : case_op_pkg
// Purpose  : Opcode enum and alternating-bit pattern helpers for case_op_pipe.
// Revision : 1.0  initial release
// ============================================================================
package case_op_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_ZERO  = 3'b000,
        OP_PAT_A = 3'b001,
        OP_PAT_5 = 3'b010,
        OP_PASS  = 3'b011,
        OP_INV   = 3'b100,
        OP_INC   = 3'b101,
        OP_ACC   = 3'b110,
        OP_ONES  = 3'b111
    } case_op_e;

    // Bit i set for odd i, limited to the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] pat_a(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = (i < width) && (i % 2 == 1);
        end
        return r;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] pat_5(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = (i < width) && (i % 2 == 0);
        end
        return r;
    endfunction

endpackage : case_op_pkg
`default_nettype wire

// File: rtl/case_op_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : case_op_pipe_if
// Purpose  : Opcode/data input channel and result output channel, valid/ready.
// Revision : 1.0  initial release
// ============================================================================
interface case_op_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface : case_op_pipe_if
`default_nettype wire

// File: rtl/case_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : case_op_decode
// Purpose  : Combinational opcode -> {result, carry} decode. Optional feature
//            macro CASE_OP_ACC_EN enables the accumulate opcode.
// Revision : 1.0  initial release
// ============================================================================
module case_op_decode
    import case_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [2:0]       op,
    input  wire logic [WIDTH-1:0] data,
    input  wire logic [WIDTH-1:0] acc,
    output logic      [WIDTH-1:0] result,
    output logic                  carry
);

    localparam logic [WIDTH-1:0] C_PAT_A = WIDTH'(pat_a(WIDTH));
    localparam logic [WIDTH-1:0] C_PAT_5 = WIDTH'(pat_5(WIDTH));

`ifndef CASE_OP_ACC_EN
    logic w_unused_acc;
    assign w_unused_acc = ^acc;
`endif

    always_comb begin
        result = '1;
        carry  = 1'b0;
        case (case_op_e'(op))
            OP_ZERO:  result = '0;
            OP_PAT_A: result = C_PAT_A;
            OP_PAT_5: result = C_PAT_5;
            OP_PASS:  result = data;
            OP_INV:   result = ~data;
            OP_INC:   {carry, result} = {1'b0, data} + {{WIDTH{1'b0}}, 1'b1};
`ifdef CASE_OP_ACC_EN
            OP_ACC:   {carry, result} = {1'b0, acc} + {1'b0, data};
`else
            OP_ACC:   result = '1;
`endif
            OP_ONES:  result = '1;
            default:  result = '1;
        endcase
    end

endmodule : case_op_decode
`default_nettype wire

// File: rtl/case_op_pipe.sv
`default_nettype none
// ============================================================================
// Module   : case_op_pipe
// Purpose  : One-deep valid/ready registered opcode unit. Optional feature
//            macro CASE_OP_ACC_EN adds the running accumulator.
// Revision : 1.0  initial release
// ============================================================================
module case_op_pipe
    import case_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    case_op_pipe_if.slave bus
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_accept;

    // Ready looks only at the output stage so a drain and a load can share a cycle.
    assign bus.in_ready  = !r_valid || bus.out_ready;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_carry = r_carry;

    case_op_decode #(.WIDTH(WIDTH)) u_decode (
        .op     (bus.in_op),
        .data   (bus.in_data),
        .acc    (w_acc),
        .result (w_result),
        .carry  (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_result;
            r_carry <= w_carry;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef CASE_OP_ACC_EN
    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            if (bus.in_op == OP_ACC) begin
                r_acc <= w_result;
            end else if (bus.in_op == OP_ZERO) begin
                r_acc <= '0;
            end
        end
    end

    assign w_acc = r_acc;
`else
    assign w_acc = '0;
`endif

endmodule : case_op_pipe
`default_nettype wire

// File: doc/case_op_pipe.md
# case_op_pipe

Registered, parametrised successor to the team's combinational opcode selector. Applies one of eight opcode-selected operations to a `WIDTH`-bit operand and delivers the result through a one-deep valid/ready pipeline register. It adds a carry flag and an optional running accumulator. It sits between an opcode/data producer and a downstream consumer that can stall.

## Interface
- `WIDTH`, default 8: operand/result width, ≥ 2.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_op`/`in_data` valid this cycle.
- `in_ready` output, 1 bit: block accepts input this cycle.
- `in_op` input, 3 bits: opcode.
- `in_data` input, `WIDTH` bits: operand.
- `out_valid` output, 1 bit: `out_data`/`out_carry` hold a result.
- `out_ready` input, 1 bit: consumer takes the result this cycle.
- `out_data` output, `WIDTH` bits: result.
- `out_carry` output, 1 bit: carry out of op 101/110, else 0.

## Operation
- Opcodes (P_A: bit i = 1 for odd i, e.g. 8'hAA; P_5 = ~P_A, e.g. 8'h55):
  - 000: zero. With the accumulator compiled in, also clears `acc`.
  - 001: P_A.
  - 010: P_5.
  - 011: `in_data`.
  - 100: `~in_data`.
  - 101: `in_data + 1`. Carry = bit out of the `WIDTH`-bit add (`all-ones + 1` gives 0, carry 1).
  - 110: accumulate. `acc + in_data`, see Configuration.
  - 111: all-ones.
- The decode is a full case with no latches. Any X/unused encoding resolves to all-ones with carry 0.
- Accept: `in_valid && in_ready`. Result, carry and `acc` update only on accept.
- `acc` is a `WIDTH`-bit register. On accepted op 110: `acc <= acc + in_data`, `out_data` = new `acc`, carry = add carry-out. `acc` wraps modulo 2^`WIDTH`.
- Output register holds its value while `out_valid && !out_ready`. `out_data` and `out_carry` are stable under stall.
- Reset (any time, including mid-transfer): `out_valid` = 0, `out_data` = 0, `out_carry` = 0, `acc` = 0. `in_ready` = 1 once reset is released. Any in-flight result is discarded.

## Timing
- `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`, with no dependence on `in_valid`.
- Latency: 1 cycle. An operand accepted at edge N is visible with `out_valid` = 1 after edge N.
- Throughput: 1 per cycle while `out_ready` = 1.
- Simultaneous drain and accept (`out_valid`, `out_ready`, `in_valid` all 1): the register loads the new result, and `out_valid` stays 1.
- Drain without accept: `out_valid` falls to 0 next cycle. `out_data` keeps its last value (don't-care).
- Back-to-back op 110 operations chain through the updated `acc` with no bubble.
- `in_valid` may drop without a transfer. The producer is not required to hold it.

## Configuration
- `CASE_OP_ACC_EN` defined: `acc` register present. Op 110 accumulates, and op 000 clears `acc`.
- Not defined: no `acc` register. Op 110 behaves as 111 (all-ones, carry 0), and op 000 is plain zero. The port list is unchanged.

## Structure
- Shared package `case_op_pkg`:
  - Opcode enum `case_op_e` (`OP_ZERO`, `OP_PAT_A`, `OP_PAT_5`, `OP_PASS`, `OP_INV`, `OP_INC`, `OP_ACC`, `OP_ONES`).
  - Parametrised pattern functions for P_A and P_5.
- One sub-module, `case_op_decode`. It is a purely combinational opcode → {result, carry} decode with inputs `op`, `data`, `acc`. The top holds the handshake, output register and `acc`.

## Test plan
- **Reset value:** Assert `rst_n` low mid-stream with `out_valid` = 1. Outputs go to 0 asynchronously. After release: `in_ready` = 1, `acc` = 0.
- **Opcode sweep** (WIDTH = 8, `in_data` = 8'h3C, `out_ready` = 1, ops 000–111): results 00, AA, 55, 3C, C3, 3D, 3C (acc path) or FF, FF. Each arrives 1 cycle after accept, all carries 0.
- **Increment wrap:** op 101 with `in_data` = 8'hFF gives `out_data` = 00, `out_carry` = 1.
- **Accumulator** (macro on): three ops 110 with 8'h80, 8'h70, 8'h20 back-to-back give 80/0, F0/0, 10/1. Then op 000 and op 110 with 8'h05 give 00, then 05.
- **Backpressure:** hold `out_ready` = 0 with `out_valid` = 1 for 5 cycles while `in_valid` = 1. `in_ready` = 0, output is stable, and `acc` is unchanged. Release: the next op is accepted in the same cycle, no results are lost or duplicated, and the scoreboard order is preserved.
- **Macro off:** op 110 with 8'h01 gives FF with carry 0, and op 000 gives 00.
